cbx_param: RTL



---
 rtl/cbx_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cbx_param.sv
// cbx_param -- X-channel connection block with a double-buffered config chain.
//
// Passes CHAN_W horizontal tracks straight through in both directions and
// drives NUM_IPIN grid input pins, each from a MUX_SIZE-input routing mux.
// Mux selects are shifted in on the ccff scan chain into a shadow register
// and copied to the active register atomically on ccff_commit. The copy
// happens only if exactly CFG_LEN bits were shifted since the last commit.
//
// Optional feature macro: CBX_CFG_PARITY_EN
//   When defined, the chain gains one extra bit (the last bit shifted, sr[0]).
//   It is chosen so that the XOR of the whole chain is 0. A commit with odd
//   parity is rejected.
//
// Ports:
//   prog_clk         in   configuration clock
//   pReset_n         in   asynchronous active-low reset
//   chanx_left_in    in   [CHAN_W]   tracks entering from the left
//   chanx_right_in   in   [CHAN_W]   tracks entering from the right
//   ccff_head        in   serial configuration data
//   ccff_en          in   shift enable
//   ccff_commit      in   one-cycle strobe, shadow -> active
//   chanx_left_out   out  [CHAN_W]   = chanx_right_in
//   chanx_right_out  out  [CHAN_W]   = chanx_left_in
//   ipin_out         out  [NUM_IPIN] mux outputs to grid pins
//   ccff_tail        out  serial data to the next block
//   cfg_valid        out  an active configuration is loaded
//   cfg_err          out  the last commit was rejected
//
// Legal parameter ranges:
//   NUM_IPIN <= CHAN_W
//   MUX_SIZE is even, 2..2*CHAN_W

module cbx_param #(
   parameter int unsigned CHAN_W   = 5,
   parameter int unsigned NUM_IPIN = 3,
   parameter int unsigned MUX_SIZE = 2
) (
   input  logic                prog_clk,
   input  logic                pReset_n,
   input  logic [CHAN_W-1:0]   chanx_left_in,
   input  logic [CHAN_W-1:0]   chanx_right_in,
   input  logic                ccff_head,
   input  logic                ccff_en,
   input  logic                ccff_commit,
   output logic [CHAN_W-1:0]   chanx_left_out,
   output logic [CHAN_W-1:0]   chanx_right_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                ccff_tail,
   output logic                cfg_valid,
   output logic                cfg_err
);

   localparam int unsigned SEL_W   = (MUX_SIZE > 2) ? $clog2(MUX_SIZE) : 1;
`ifdef CBX_CFG_PARITY_EN
   localparam int unsigned PAR_W   = 1;
`else
   localparam int unsigned PAR_W   = 0;
`endif
   localparam int unsigned SEL_TOT = NUM_IPIN * SEL_W;
   localparam int unsigned CFG_LEN = SEL_TOT + PAR_W;
   // The counter must be able to hold CFG_LEN+1, its saturation value.
   localparam int unsigned CNT_W   = $clog2(CFG_LEN + 2);
   localparam int unsigned TAPS    = 1 << SEL_W;

   logic [CFG_LEN-1:0] sr;
   logic [CFG_LEN-1:0] sr_nxt;
   logic [SEL_TOT-1:0] active;
   logic [CNT_W-1:0]   cnt;
   logic               cfg_ok;

   // Passthrough: purely combinational, independent of configuration and reset.
   assign chanx_left_out  = chanx_right_in;
   assign chanx_right_out = chanx_left_in;

   // The first bit shifted in ends up in the MSB, which feeds the next block.
   if (CFG_LEN > 1) begin : g_shift_wide
      assign sr_nxt = {sr[CFG_LEN-2:0], ccff_head};
   end else begin : g_shift_one
      assign sr_nxt = ccff_head;
   end

   assign ccff_tail = sr[CFG_LEN-1];

`ifdef CBX_CFG_PARITY_EN
   assign cfg_ok = (cnt == CNT_W'(CFG_LEN)) && !(^sr);
`else
   assign cfg_ok = (cnt == CNT_W'(CFG_LEN));
`endif

   // A commit judges the pre-shift shadow and count, even when a shift
   // happens on the same edge. The parity bit (sr[0]) is not kept in
   // active, so select field i sits at sr[PAR_W + i*SEL_W].
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         sr        <= '0;
         active    <= '0;
         cnt       <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (ccff_en) begin
            sr <= sr_nxt;
         end
         if (ccff_commit) begin
            cnt <= ccff_en ? CNT_W'(1) : '0;
            if (cfg_ok) begin
               active    <= sr[CFG_LEN-1 -: SEL_TOT];
               cfg_valid <= 1'b1;
               cfg_err   <= 1'b0;
            end else begin
               cfg_err   <= 1'b1;
            end
         end else if (ccff_en && (cnt != CNT_W'(CFG_LEN + 1))) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Each mux table is padded up to 2**SEL_W entries with constant zeros.
   // A select of MUX_SIZE or more therefore yields 0.
   // Tap j of ipin i reads track (i + j/2) mod CHAN_W: even j from the
   // left and odd j from the right.
   for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
      logic [TAPS-1:0]  tap;
      logic [SEL_W-1:0] sel;

      assign sel = active[gi*SEL_W +: SEL_W];

      for (genvar gj = 0; gj < TAPS; gj++) begin : g_tap
         if (gj >= MUX_SIZE) begin : g_pad
            assign tap[gj] = 1'b0;
         end else if ((gj % 2) == 0) begin : g_left
            assign tap[gj] = chanx_left_in[(gi + gj/2) % CHAN_W];
         end else begin : g_right
            assign tap[gj] = chanx_right_in[(gi + gj/2) % CHAN_W];
         end
      end

      assign ipin_out[gi] = cfg_valid & tap[sel];
   end

endmodule
